// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//
// Program counter with a small return-address stack. One operation per cycle,
// chosen by fixed priority: ret > call > load > branch > count. Requests that
// lose the priority contest in the same cycle are dropped.
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   clear_n       synchronous active-low reset (overrides every other input)
//   hold          freezes PC, stack and error flag setting while high
//   count         address <= address + 1
//   load          address <= jump_address
//   jump_address  target for load and call
//   branch        address <= address + offset (signed, modulo 2^ADDR_WIDTH)
//   offset        two's-complement branch displacement
//   call          push address+1, then jump to jump_address
//   ret           pop the top of the stack into address
//   clear_flags   clears overflow/underflow (acts even while hold is high)
//   address       current PC (registered)
//   stack_level   number of valid stack entries
//   stack_empty   stack_level == 0
//   stack_full    stack_level == STACK_DEPTH
//   overflow      sticky: call attempted on a full stack
//   underflow     sticky: ret attempted on an empty stack
// -----------------------------------------------------------------------------
module program_sequencer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 clear_n,
   input  logic                                 hold,
   input  logic                                 count,
   input  logic                                 load,
   input  logic [ADDR_WIDTH-1:0]                jump_address,
   input  logic                                 branch,
   input  logic [ADDR_WIDTH-1:0]                offset,
   input  logic                                 call,
   input  logic                                 ret,
   input  logic                                 clear_flags,
   output logic [ADDR_WIDTH-1:0]                address,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
   output logic                                 stack_empty,
   output logic                                 stack_full,
   output logic                                 overflow,
   output logic                                 underflow
);

   localparam int LW = $clog2(STACK_DEPTH + 1);
   // Index width into the storage array; at least one bit even for depth 1.
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   // Return-address storage. Entries at or above level_q are never read,
   // so the array carries no reset.
   logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

   logic                  empty, full;
   logic [IW-1:0]         push_idx, pop_idx;
   logic [LW-1:0]         level_m1;
   logic                  push_en;
   logic [ADDR_WIDTH-1:0] push_data;

   assign empty    = (level_q == LW'(0));
   assign full     = (level_q == LW'(STACK_DEPTH));
   assign level_m1 = level_q - LW'(1);
   // Truncation is safe: push only happens when not full (level < DEPTH),
   // pop only when not empty (level-1 < DEPTH).
   assign push_idx = level_q[IW-1:0];
   assign pop_idx  = level_m1[IW-1:0];

   always_comb begin
      addr_d    = addr_q;
      level_d   = level_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push_en   = 1'b0;
      push_data = addr_q + ADDR_WIDTH'(1);

      // Clearing is applied first so that an error raised in the same
      // cycle overrides it and the flag reads 1.
      if (clear_flags) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (!hold) begin
         if (ret) begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               addr_d  = stack_q[pop_idx];
               level_d = level_m1;
            end
         end else if (call) begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               push_en = 1'b1;
               level_d = level_q + LW'(1);
               addr_d  = jump_address;
            end
         end else if (load) begin
            addr_d = jump_address;
         end else if (branch) begin
            // Equal-width modular add is the sign-extended add.
            addr_d = addr_q + offset;
         end else if (count) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         addr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clear_n && push_en) begin
         stack_q[push_idx] <= push_data;
      end
   end

   assign address     = addr_q;
   assign stack_level = level_q;
   assign stack_empty = empty;
   assign stack_full  = full;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
//
// Directed bench for program_sequencer (ADDR_WIDTH=8, STACK_DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_program_sequencer;

   localparam int AW = 8;
   localparam int SD = 4;
   localparam int LW = $clog2(SD + 1);

   logic          clk = 1'b0;
   logic          clear_n;
   logic          hold;
   logic          count;
   logic          load;
   logic [AW-1:0] jump_address;
   logic          branch;
   logic [AW-1:0] offset;
   logic          call;
   logic          ret;
   logic          clear_flags;
   logic [AW-1:0] address;
   logic [LW-1:0] stack_level;
   logic          stack_empty;
   logic          stack_full;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int errors = 0;

   // clock
   always #5 clk = ~clk;

   program_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .hold         (hold),
      .count        (count),
      .load         (load),
      .jump_address (jump_address),
      .branch       (branch),
      .offset       (offset),
      .call         (call),
      .ret          (ret),
      .clear_flags  (clear_flags),
      .address      (address),
      .stack_level  (stack_level),
      .stack_empty  (stack_empty),
      .stack_full   (stack_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // driver tasks
   task automatic idle();
      hold = 0; count = 0; load = 0; branch = 0; call = 0; ret = 0;
      clear_flags = 0; jump_address = '0; offset = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] lvl);
      check({tag, "_addr"}, 32'(address), 32'(a));
      check({tag, "_lvl"}, 32'(stack_level), 32'(lvl));
   endtask

   task automatic do_load(input logic [AW-1:0] a);
      idle(); load = 1; jump_address = a; tick(); idle();
   endtask

   initial begin
      idle();
      clear_n = 0;
      tick(); tick();
      // reset state
      check_state("rst", 8'h00, 0);
      check("rst_empty", 32'(stack_empty), 1);
      check("rst_full", 32'(stack_full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_unf", 32'(underflow), 0);
      clear_n = 1;

      // load then count
      load = 1; jump_address = 8'hA5; tick(); idle();
      check("load_a5", 32'(address), 32'h A5);
      count = 1;
      tick(); check("cnt_a6", 32'(address), 32'hA6);
      tick(); check("cnt_a7", 32'(address), 32'hA7);
      tick(); check("cnt_a8", 32'(address), 32'hA8);
      idle();

      // count wrap
      do_load(8'hFE);
      count = 1;
      tick(); check("wrap_ff", 32'(address), 32'hFF);
      tick(); check("wrap_00", 32'(address), 32'h00);
      tick(); check("wrap_01", 32'(address), 32'h01);
      idle();

      // branches both directions
      do_load(8'h02);
      branch = 1; offset = 8'hFC; tick(); idle();
      check("br_neg", 32'(address), 32'hFE);
      do_load(8'hF0);
      branch = 1; offset = 8'h20; tick(); idle();
      check("br_pos", 32'(address), 32'h10);

      // no operation
      tick(); check_state("nop", 8'h10, 0);

      // nested call / ret from 10
      call = 1; jump_address = 8'h40; tick(); idle();
      check_state("call1", 8'h40, 1);
      call = 1; jump_address = 8'h80; tick(); idle();
      check_state("call2", 8'h80, 2);
      ret = 1; tick(); idle();
      check_state("ret1", 8'h41, 1);
      ret = 1; tick(); idle();
      check_state("ret2", 8'h11, 0);
      check("ret2_empty", 32'(stack_empty), 1);

      // fill, overflow, drain, underflow
      do_load(8'h00);
      call = 1;
      jump_address = 8'h10; tick();
      jump_address = 8'h20; tick();
      jump_address = 8'h30; tick();
      jump_address = 8'h40; tick();
      check_state("fill", 8'h40, 4);
      check("fill_full", 32'(stack_full), 1);
      check("fill_ovf0", 32'(overflow), 0);
      jump_address = 8'h50; tick(); idle();
      check_state("ovf", 8'h40, 4);
      check("ovf_flag", 32'(overflow), 1);
      ret = 1;
      tick(); check_state("pop1", 8'h31, 3);
      check("pop1_ovf_sticky", 32'(overflow), 1);
      tick(); check_state("pop2", 8'h21, 2);
      tick(); check_state("pop3", 8'h11, 1);
      tick(); check_state("pop4", 8'h01, 0);
      tick(); idle();
      check_state("unf", 8'h01, 0);
      check("unf_flag", 32'(underflow), 1);
      clear_flags = 1; tick(); idle();
      check("clr_ovf", 32'(overflow), 0);
      check("clr_unf", 32'(underflow), 0);

      // clear coinciding with a new error: error wins
      clear_flags = 1; ret = 1; tick(); idle();
      check("clr_vs_err", 32'(underflow), 1);
      // clear acts while held
      hold = 1; clear_flags = 1; tick(); idle();
      check("clr_hold", 32'(underflow), 0);

      // priority: call beats load and count
      call = 1; load = 1; count = 1; jump_address = 8'h60; tick(); idle();
      check_state("pri_call", 8'h60, 1);
      // ret beats call
      ret = 1; call = 1; jump_address = 8'h70; tick(); idle();
      check_state("pri_ret", 8'h02, 0);
      // load beats branch
      load = 1; branch = 1; offset = 8'h05; jump_address = 8'h33; tick(); idle();
      check("pri_load", 32'(address), 32'h33);
      // hold blocks ret on empty stack and count
      hold = 1; ret = 1; tick();
      check_state("hold_ret", 8'h33, 0);
      check("hold_unf", 32'(underflow), 0);
      ret = 0; count = 1; tick(); idle();
      check("hold_cnt", 32'(address), 32'h33);

      // reset mid-sequence discards the stack
      call = 1; jump_address = 8'h10; tick();
      jump_address = 8'h20; tick(); idle();
      check_state("pre_rst", 8'h20, 2);
      clear_n = 0; hold = 1; count = 1; tick(); idle();
      clear_n = 1;
      check_state("mid_rst", 8'h00, 0);
      ret = 1; tick(); idle();
      check("rst_ret_unf", 32'(underflow), 1);
      check_state("rst_ret", 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
